// File: rtl/riscv_pkg.sv
// Shared pipeline-control types for the hazard unit.
// FSM state encoding, control bundle and the load-use detector.
package riscv_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic ifid_flush;
        logic idex_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RUN = '{
        pc_en:      1'b1,
        ifid_en:    1'b1,
        idex_en:    1'b1,
        exmem_en:   1'b1,
        ifid_flush: 1'b0,
        idex_flush: 1'b0
    };

    localparam hz_ctrl_t CTRL_FREEZE = '{
        pc_en:      1'b0,
        ifid_en:    1'b0,
        idex_en:    1'b0,
        exmem_en:   1'b0,
        ifid_flush: 1'b0,
        idex_flush: 1'b0
    };

    localparam hz_ctrl_t CTRL_LOAD_USE = '{
        pc_en:      1'b0,
        ifid_en:    1'b0,
        idex_en:    1'b1,
        exmem_en:   1'b1,
        ifid_flush: 1'b0,
        idex_flush: 1'b1
    };

    localparam hz_ctrl_t CTRL_BRANCH = '{
        pc_en:      1'b1,
        ifid_en:    1'b1,
        idex_en:    1'b1,
        exmem_en:   1'b1,
        ifid_flush: 1'b1,
        idex_flush: 1'b1
    };

    // x0 never carries a value, so a load to x0 cannot create a dependency.
    function automatic logic load_use_hit(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use_rs1,
        input logic       use_rs2,
        input logic [4:0] rd,
        input logic       mem_read
    );
        logic m1;
        logic m2;
        m1 = use_rs1 && (rs1 == rd);
        m2 = use_rs2 && (rs2 == rd);
        return mem_read && (rd != 5'd0) && (m1 || m2);
    endfunction

    // A taken branch squashes the dependent instruction instead of stalling it.
    function automatic hz_ctrl_t run_ctrl(
        input logic lu,
        input logic br
    );
        hz_ctrl_t c;
        c = CTRL_RUN;
        if (br) begin
            c = CTRL_BRANCH;
        end else if (lu) begin
            c = CTRL_LOAD_USE;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating event counter used for the hazard performance counters.
// Sticks at all-ones instead of wrapping.
module hazard_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count events, holding at the maximum value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, dmem freeze.
// Performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_pcsel,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    import riscv_pkg::*;

    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    hz_state_t     state;
    logic [WW-1:0] wait_cnt;
    logic          bus_err_q;
    logic          lu_hit;
    logic          tmo_hit;
    logic          freeze;
    hz_ctrl_t      ctrl;

    assign lu_hit = load_use_hit(id_rs1, id_rs2, id_use_rs1,
                                 id_use_rs2, ex_rd, ex_mem_read);

    assign tmo_hit = (wait_cnt == WW'(MAX_WAIT));

    // Decide whether the pipe is frozen by an outstanding dmem access.
    always_comb begin
        freeze = 1'b0;
        unique case (state)
            RUN:      freeze = dmem_req && !dmem_ack;
            MEM_WAIT: freeze = !dmem_ack && !tmo_hit;
            default:  freeze = 1'b0;
        endcase
    end

    // Pick the control bundle: reset, then freeze, then branch/load-use.
    always_comb begin
        ctrl = CTRL_RUN;
        priority case (1'b1)
            !reset_n: ctrl = CTRL_RUN;
            freeze:   ctrl = CTRL_FREEZE;
            default:  ctrl = run_ctrl(lu_hit, ex_pcsel);
        endcase
    end

    assign pc_en      = ctrl.pc_en;
    assign ifid_en    = ctrl.ifid_en;
    assign idex_en    = ctrl.idex_en;
    assign exmem_en   = ctrl.exmem_en;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_flush = ctrl.idex_flush;
    assign bus_err    = bus_err_q;

    // Wait-state tracking, timeout and sticky bus error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    wait_cnt <= '0;
                    if (dmem_req && !dmem_ack) begin
                        state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (tmo_hit) begin
                        state     <= RUN;
                        wait_cnt  <= '0;
                        bus_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = !ctrl.pc_en;
    assign flush_inc = ctrl.ifid_flush;

    hazard_sat_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (stall_inc),
        .count   (stall_cnt)
    );

    hazard_sat_cnt #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (flush_inc),
        .count   (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, corner sequences
// and randomized traffic against a behavioural reference model.
module tb_hazard_ctrl;

    localparam int MW = 4;
    localparam int CW = 8;
    localparam logic [63:0] CMAX = (64'd1 << CW) - 64'd1;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [5:0] C_RUN  = 6'b111100;
    localparam logic [5:0] C_FRZ  = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b001101;
    localparam logic [5:0] C_BR   = 6'b111111;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2;
    logic          ex_mem_read, ex_pcsel, dmem_req, dmem_ack;
    logic          pc_en, ifid_en, idex_en, exmem_en;
    logic          ifid_flush, idex_flush, bus_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(
        .MAX_WAIT (MW),
        .CNT_W    (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_pcsel    (ex_pcsel),
        .dmem_req    (dmem_req),
        .dmem_ack    (dmem_ack),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .bus_err     (bus_err),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: memory wait in progress, cycles waited so far
    bit          m_wait;
    int          m_age;
    bit          m_err;
    logic [63:0] m_stall;
    logic [63:0] m_flush;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       pc;
        logic       rq;
        logic       ak;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [5:0] got6();
        return {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush};
    endfunction

    function automatic logic [5:0] model_ctrl();
        bit lu;
        bit frz;
        if (!reset_n) return C_RUN;
        if (m_wait) frz = !dmem_ack && (m_age < MW);
        else        frz = dmem_req && !dmem_ack;
        if (frz) return C_FRZ;
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) ||
              (id_use_rs2 && id_rs2 == ex_rd));
        if (ex_pcsel) return C_BR;
        if (lu) return C_LU;
        return C_RUN;
    endfunction

    task automatic mdl_reset();
        m_wait  = 1'b0;
        m_age   = 0;
        m_err   = 1'b0;
        m_stall = 64'd0;
        m_flush = 64'd0;
    endtask

    task automatic mdl_step(input logic [5:0] mc);
        if (!reset_n) return;
        if (!mc[5] && m_stall < CMAX) m_stall = m_stall + 64'd1;
        if (mc[1] && m_flush < CMAX) m_flush = m_flush + 64'd1;
        if (m_wait) begin
            if (dmem_ack) begin
                m_wait = 1'b0;
            end else if (m_age == MW) begin
                m_wait = 1'b0;
                m_err  = 1'b1;
            end else begin
                m_age = m_age + 1;
            end
        end else if (dmem_req && !dmem_ack) begin
            m_wait = 1'b1;
            m_age  = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1, input logic u2,
                          input logic [4:0] rd, input logic mr,
                          input logic pc, input logic rq,
                          input logic ak);
        id_rs1      = r1;
        id_rs2      = r2;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        ex_rd       = rd;
        ex_mem_read = mr;
        ex_pcsel    = pc;
        dmem_req    = rq;
        dmem_ack    = ak;
    endtask

    task automatic idle_in();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // one clock: compare at negedge, then advance the model on posedge
    task automatic tick(input string tag, input logic [5:0] exp);
        logic [5:0] mc;
        @(negedge clk);
        mc = model_ctrl();
        chk({tag, " ctrl"}, {58'd0, got6()}, {58'd0, exp});
        chk({tag, " bus_err"}, {63'd0, bus_err}, {63'd0, m_err});
        chk({tag, " stall_cnt"}, {{(64-CW){1'b0}}, stall_cnt},
            PERF ? m_stall : 64'd0);
        chk({tag, " flush_cnt"}, {{(64-CW){1'b0}}, flush_cnt},
            PERF ? m_flush : 64'd0);
        @(posedge clk);
        mdl_step(mc);
        #1;
    endtask

    task automatic tick_m(input string tag);
        tick(tag, model_ctrl());
    endtask

    // asynchronous reset pulse starting mid-cycle, with hostile inputs
    task automatic do_reset(input string tag);
        set_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        mdl_reset();
        #1;
        chk({tag, " rst ctrl"}, {58'd0, got6()}, {58'd0, C_RUN});
        chk({tag, " rst bus_err"}, {63'd0, bus_err}, 64'd0);
        chk({tag, " rst stall"}, {{(64-CW){1'b0}}, stall_cnt}, 64'd0);
        chk({tag, " rst flush"}, {{(64-CW){1'b0}}, flush_cnt}, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle_in();
    endtask

    initial begin
        tbl[0] = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0,
                   C_RUN, "no_hazard"};
        tbl[1] = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0,
                   C_LU, "lu_rs1_x5"};
        tbl[2] = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0,
                   C_RUN, "after_lu"};
        tbl[3] = '{5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0,
                   C_LU, "lu_rs2"};
        tbl[4] = '{5'd9, 5'd1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0,
                   C_RUN, "rs1_unused"};
        tbl[5] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0,
                   C_RUN, "load_x0"};
        tbl[6] = '{5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0,
                   C_RUN, "not_load"};
        tbl[7] = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0,
                   C_BR, "branch"};
        tbl[8] = '{5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0,
                   C_BR, "branch_over_lu"};
        tbl[9] = '{5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1,
                   C_LU, "req_ack_same"};

        reset_n = 1'b1;
        idle_in();
        mdl_reset();
        @(posedge clk);
        #1;
        do_reset("init");

        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2,
                   tbl[i].rd, tbl[i].mr, tbl[i].pc, tbl[i].rq,
                   tbl[i].ak);
            tick(tbl[i].name, tbl[i].exp);
        end

        // dmem access acked on the fourth cycle; branch pending throughout
        do_reset("mw");
        set_in(5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        tick("mw_frz0", C_FRZ);
        tick("mw_frz1", C_FRZ);
        tick("mw_frz2", C_FRZ);
        dmem_ack = 1'b1;
        tick("mw_release", C_BR);
        idle_in();
        dmem_ack = 1'b0;
        tick("mw_run", C_RUN);
        chk("mw stall_cnt 3", {{(64-CW){1'b0}}, stall_cnt},
            PERF ? 64'd3 : 64'd0);

        // dmem never acks: timeout releases the pipe and sets bus_err
        do_reset("to");
        set_in(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < MW + 1; i++) tick("to_frz", C_FRZ);
        tick("to_release", C_RUN);
        chk("to bus_err set", {63'd0, bus_err}, 64'd1);
        idle_in();
        for (int i = 0; i < 3; i++) tick("to_sticky", C_RUN);
        chk("to bus_err sticky", {63'd0, bus_err}, 64'd1);
        do_reset("to_clr");

        // reset in the middle of a wait abandons it
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("mid_frz0", C_FRZ);
        tick("mid_frz1", C_FRZ);
        do_reset("mid");
        tick("mid_run", C_RUN);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rnd");
            end else begin
                set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 4) == 0),
                       1'($urandom_range(0, 9) < 3),
                       1'($urandom_range(0, 9) < 4));
                tick_m("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 255: data-memory wait cycles tolerated before timeout.
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 id_rs1, id_rs2  in  5 each  source register addresses of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads rs1 / rs2.
REQ-007 ex_rd  in  5  destination register of the instruction in EX.
REQ-008 ex_mem_read  in  1  the EX instruction is a load.
REQ-009 ex_pcsel  in  1  branch/jump taken, resolved in EX.
REQ-010 dmem_req, dmem_ack  in  1 each  MEM-stage access request / completion.
REQ-011 pc_en, ifid_en, idex_en, exmem_en  out  1 each  hold-enable of the PC and pipeline registers (1 = advance).
REQ-012 ifid_flush, idex_flush  out  1 each  load a bubble (all-zero controls) into IF/ID / ID/EX.
REQ-013 bus_err  out  1  sticky data-memory timeout flag.
REQ-014 stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-015 The FSM SHALL have two states: RUN and MEM_WAIT.
REQ-016 Default outputs in RUN with no hazard: all enables 1, both flushes 0.
REQ-017 Load-use hazard = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-018 Load-use response, same cycle: pc_en=0, ifid_en=0, idex_flush=1. This inserts exactly one bubble.
REQ-019 Branch response, ex_pcsel=1, same cycle: ifid_flush=1, idex_flush=1, pc_en=1.
REQ-020 Branch SHALL override load-use; the dependent ID instruction is squashed, not stalled.
REQ-021 In RUN, dmem_req=1 with dmem_ack=0 SHALL freeze the pipe in the same cycle: all enables 0, both flushes 0. Next state is MEM_WAIT.
REQ-022 dmem_req with dmem_ack=1 in the same cycle SHALL cause no stall.
REQ-023 In MEM_WAIT with dmem_ack=0, the freeze SHALL continue and wait_cnt SHALL increment.
REQ-024 In MEM_WAIT with dmem_ack=1 (release cycle): outputs follow the RUN rules (REQ-016..020), next state RUN, wait_cnt cleared.
REQ-025 In MEM_WAIT, reaching wait_cnt==MAX_WAIT SHALL set bus_err and be treated as the release cycle.
REQ-026 Freeze SHALL take priority over branch and load-use. ex_pcsel held during a freeze is acted on in the release cycle.
REQ-027 bus_err SHALL stay set until reset.

Reset
REQ-028 reset_n low: state RUN, wait_cnt 0, bus_err 0, counters 0, immediately and regardless of clk.
REQ-029 During reset, outputs SHALL be the RUN no-hazard values.
REQ-030 Reset asserted mid-MEM_WAIT SHALL abandon the wait with no bus_err.

Configuration
REQ-031 With HAZARD_PERF_EN defined:
- stall_cnt increments in every cycle with pc_en=0.
- flush_cnt increments in every cycle with a branch flush.
- Both counters saturate at all-ones.
REQ-032 Without HAZARD_PERF_EN: stall_cnt and flush_cnt are constant 0 and no counter flops are built.

Structure
REQ-033 The state encoding (RUN=0, MEM_WAIT=1) SHALL live in the shared package/header riscv_pkg.
REQ-034 The saturating counter SHALL be sub-module hazard_sat_cnt, instantiated twice under HAZARD_PERF_EN.

Verification
REQ-035 Load x5 in EX, ID add reading x5 -> one cycle pc_en=0, ifid_en=0, idex_flush=1, then normal flow.
REQ-036 Load x0 in EX, ID reading x0 -> no stall.
REQ-037 ex_pcsel=1 together with a load-use match -> ifid_flush=1, idex_flush=1, pc_en=1, no stall; flush_cnt+1.
REQ-038 dmem_req=1, ack after 3 cycles -> 3 frozen cycles, state RUN after the ack edge; stall_cnt=3.
REQ-039 MAX_WAIT=4, ack never arrives -> bus_err rises after 4 wait cycles and the pipe releases; bus_err stays high until reset_n pulses.
REQ-040 reset_n low during MEM_WAIT -> immediate RUN, all counters 0, bus_err 0.
